// File: rtl/cnn_layer_sched.sv
// cnn_layer_sched: multi-layer scheduler for the CNN engine controller.
// Holds a per-layer config table and runs back-to-back engine passes: for each
// pass it presents the layer's config word, pulses cnn_en, waits for the
// engine to drop its done level, then waits for done to come back.
// Optional build macro: LAYER_PERF_EN adds a per-pass cycle counter and the
// layer_cyc output (plus the CYC_W parameter).
module cnn_layer_sched #(
    parameter int MAX_LAYERS = 8,
    parameter int LAYER_W    = 3,
    parameter int CFG_W      = 16
`ifdef LAYER_PERF_EN
    ,
    parameter int CYC_W      = 32
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [LAYER_W-1:0] cfg_addr,
    input  logic [CFG_W-1:0]   cfg_wdata,
    input  logic [LAYER_W:0]   num_layers,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic [LAYER_W-1:0] layer_idx,
    output logic [CFG_W-1:0]   cnn_cfg,
    output logic               cnn_en,
`ifdef LAYER_PERF_EN
    output logic [CYC_W-1:0]   layer_cyc,
`endif
    input  logic               cnn_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FIRE,
        S_ARM,
        S_WAIT,
        S_NEXT,
        S_FIN
    } state_t;

    localparam logic [LAYER_W:0] MAX_N = (LAYER_W+1)'(MAX_LAYERS);
    localparam logic [LAYER_W:0] ONE_N = (LAYER_W+1)'(1);

    state_t             state_q;
    logic [LAYER_W-1:0] idx_q;
    logic [LAYER_W:0]   n_q;
    logic               abort_q;
    logic               busy_q;
    logic               done_q;
    logic               aborted_q;
    logic [LAYER_W-1:0] layer_idx_q;
    logic [CFG_W-1:0]   cfg_q;
    logic               en_q;

    logic [CFG_W-1:0]   cfg_mem [MAX_LAYERS];

    logic [LAYER_W:0]   n_clamp_d;
    logic               last_pass_d;
    logic               stop_d;

    // Requested pass count is clamped to the table depth; idx therefore never wraps.
    assign n_clamp_d   = (num_layers > MAX_N) ? MAX_N : num_layers;
    assign last_pass_d = ({1'b0, idx_q} == (n_q - ONE_N));
    // An abort arriving in the NEXT cycle itself is honoured as well as the sticky flag.
    assign stop_d      = last_pass_d || abort_q || abort;

    // Config table: writable only while idle, never cleared by reset.
    always_ff @(posedge clk) begin
        if (cfg_we && (state_q == S_IDLE)) begin
            cfg_mem[cfg_addr] <= cfg_wdata;
        end
    end

    // Pass sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            n_q         <= '0;
            abort_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            layer_idx_q <= '0;
            cfg_q       <= '0;
            en_q        <= 1'b0;
        end else begin
            en_q   <= 1'b0;
            done_q <= 1'b0;
            if ((state_q != S_IDLE) && abort) begin
                abort_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (num_layers != '0) begin
                            n_q       <= n_clamp_d;
                            idx_q     <= '0;
                            busy_q    <= 1'b1;
                            abort_q   <= 1'b0;
                            aborted_q <= 1'b0;
                            state_q   <= S_LOAD;
                        end else begin
                            // Empty run: report completion without ever going busy.
                            done_q    <= 1'b1;
                            aborted_q <= 1'b0;
                        end
                    end
                end
                S_LOAD: begin
                    cfg_q       <= cfg_mem[idx_q];
                    layer_idx_q <= idx_q;
                    state_q     <= S_FIRE;
                end
                S_FIRE: begin
                    en_q    <= 1'b1;
                    state_q <= S_ARM;
                end
                S_ARM: begin
                    // The engine's done level is stale until it has seen cnn_en and dropped.
                    if (!cnn_done) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnn_done) begin
                        state_q <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (stop_d) begin
                        done_q    <= 1'b1;
                        aborted_q <= abort_q || abort;
                        state_q   <= S_FIN;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_FIN: begin
                    // done (raised on entry) and busy drop on the same edge.
                    busy_q    <= 1'b0;
                    aborted_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign layer_idx = layer_idx_q;
    assign cnn_cfg   = cfg_q;
    assign cnn_en    = en_q;

`ifdef LAYER_PERF_EN
    logic [CYC_W-1:0] cyc_q;
    logic [CYC_W-1:0] layer_cyc_q;

    function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Per-pass cycle counter: cleared at FIRE, counts ARM/WAIT cycles, latched entering NEXT.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q       <= '0;
            layer_cyc_q <= '0;
        end else begin
            case (state_q)
                S_FIRE: begin
                    cyc_q <= '0;
                end
                S_ARM: begin
                    cyc_q <= sat_inc(cyc_q);
                end
                S_WAIT: begin
                    cyc_q <= sat_inc(cyc_q);
                    if (cnn_done) begin
                        layer_cyc_q <= sat_inc(cyc_q);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign layer_cyc = layer_cyc_q;
`endif

endmodule

// File: tb/tb_cnn_layer_sched.sv
// Self-checking bench for cnn_layer_sched with a simple engine model whose
// done level returns DLY cycles after it samples cnn_en.
module tb_cnn_layer_sched;

    localparam int DLY = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [15:0] cfg_wdata = '0;
    logic [3:0]  num_layers = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        busy, done, aborted, cnn_en;
    logic [2:0]  layer_idx;
    logic [15:0] cnn_cfg;
    logic        cnn_done;
`ifdef LAYER_PERF_EN
    logic [31:0] layer_cyc;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    cnn_layer_sched dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .num_layers (num_layers),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .layer_idx  (layer_idx),
        .cnn_cfg    (cnn_cfg),
        .cnn_en     (cnn_en),
`ifdef LAYER_PERF_EN
        .layer_cyc  (layer_cyc),
`endif
        .cnn_done   (cnn_done)
    );

    always #5 clk = ~clk;

    // Engine model: done drops when cnn_en is sampled, rises DLY edges later.
    logic eng_busy;
    int   eng_cnt;
    always @(posedge clk) begin
        if (rst) begin
            cnn_done <= 1'b1;
            eng_busy <= 1'b0;
            eng_cnt  <= 0;
        end else if (cnn_en) begin
            cnn_done <= 1'b0;
            eng_busy <= 1'b1;
            eng_cnt  <= 1;
        end else if (eng_busy) begin
            if (eng_cnt == DLY) begin
                cnn_done <= 1'b1;
                eng_busy <= 1'b0;
            end else begin
                eng_cnt <= eng_cnt + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    typedef struct {
        int nl;
        int abort_pass;   // pass index during which abort is pulsed, -1 = none
        bit abort_w_start;
        bit poke;         // hammer cfg_we/start while busy
        int exp_passes;
        bit exp_ab;
    } vec_t;

    vec_t vecs[7];

    task automatic run_job(input vec_t v);
        int  ens;
        int  cyc;
        bit  got_done;
        bit  ab_sent;
        ens = 0; cyc = 0; got_done = 0; ab_sent = 0;
        @(negedge clk);
        num_layers = 4'(v.nl);
        start      = 1'b1;
        abort      = v.abort_w_start;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        while (!got_done && cyc < 3000) begin
            if (cnn_en) begin
                chk("cnn_cfg", cnn_cfg, 64'(16'h0011 * (ens + 1)));
                chk("layer_idx", layer_idx, 64'(ens));
                chk("busy_in_run", busy, 1);
`ifdef LAYER_PERF_EN
                if (ens > 0) chk("layer_cyc_mid", layer_cyc, DLY + 2);
`endif
                ens++;
            end
            if (done) begin
                got_done = 1;
                chk("aborted", aborted, v.exp_ab);
                chk("busy_at_done", busy, 1);
            end
            abort = 1'b0;
            if (v.abort_pass >= 0 && ens == v.abort_pass + 1 && !ab_sent) begin
                abort   = 1'b1;
                ab_sent = 1;
            end
            if (v.poke && !got_done) begin
                cfg_we     = 1'b1;
                cfg_addr   = 3'(ens);
                cfg_wdata  = 16'hDEAD;
                start      = 1'b1;
                num_layers = 4'd1;
            end else begin
                cfg_we = 1'b0;
                start  = 1'b0;
            end
            if (!got_done) begin
                @(negedge clk);
                cyc++;
            end
        end
        abort = 1'b0;
        chk("done_seen", got_done, 1);
        chk("passes", ens, v.exp_passes);
`ifdef LAYER_PERF_EN
        chk("layer_cyc_end", layer_cyc, DLY + 2);
`endif
        @(negedge clk);
        chk("busy_after", busy, 0);
        chk("done_after", done, 0);
    endtask

    initial begin
        int ens;
        int cyc;
        vecs[0] = '{3,  -1, 0, 0, 3, 0};
        vecs[1] = '{4,   1, 0, 0, 2, 1};
        vecs[2] = '{1,  -1, 0, 0, 1, 0};
        vecs[3] = '{15, -1, 0, 1, 8, 0};
        vecs[4] = '{8,  -1, 0, 0, 8, 0};
        vecs[5] = '{2,  -1, 1, 0, 2, 0};
        vecs[6] = '{9,  -1, 0, 0, 8, 0};

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle after reset: everything stays low.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("reset_idle", {busy, done, aborted, layer_idx, cnn_cfg, cnn_en}, 0);
`ifdef LAYER_PERF_EN
            chk("reset_cyc", layer_cyc, 0);
`endif
        end

        // Fill the table.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cfg_we    = 1'b1;
            cfg_addr  = 3'(i);
            cfg_wdata = 16'(16'h0011 * (i + 1));
        end
        @(negedge clk);
        cfg_we = 1'b0;

        // Zero-layer run: done one cycle later, never busy.
        @(negedge clk);
        num_layers = 4'd0;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_aborted", aborted, 0);
        @(negedge clk);
        chk("zero_done_fall", done, 0);
        chk("zero_busy2", busy, 0);
        chk("zero_no_en", cnn_en, 0);

        for (int k = 0; k < 7; k++) begin
            run_job(vecs[k]);
        end

        // Reset in the middle of pass 1.
        @(negedge clk);
        num_layers = 4'd3;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ens = 0; cyc = 0;
        while (ens < 2 && cyc < 200) begin
            if (cnn_en) ens++;
            @(negedge clk);
            cyc++;
        end
        chk("midrst_setup", ens, 2);
        repeat (4) @(negedge clk);
        chk("midrst_busy_pre", busy, 1);
        chk("midrst_idx_pre", layer_idx, 1);
`ifdef LAYER_PERF_EN
        chk("midrst_cyc_pre", layer_cyc, DLY + 2);
`endif
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_outs", {busy, done, aborted, layer_idx, cnn_cfg, cnn_en}, 0);
`ifdef LAYER_PERF_EN
        chk("midrst_cyc", layer_cyc, 0);
`endif
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("midrst_quiet", {busy, cnn_en}, 0);
        end

        // Table survives reset; run again.
        run_job(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
